// File: rtl/pix_pkg.sv
// Shared types and constants for the pixel FIFO reader.
package pix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int CNT_W      = OCC_W + 1;

endpackage

// File: rtl/pix_skid_buf.sv
// In-order skid buffer: entry 0 is the head; a pop shifts the remaining entries down
// while a push lands in the first free slot after that shift.
module pix_skid_buf
  import pix_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_W-1:0]      occupancy
);

  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] entry_reg;
  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] entry_next;
  logic [OCC_W-1:0]                      occ_reg;
  logic [OCC_W-1:0]                      occ_next;
  logic [OCC_W-1:0]                      wr_idx;

  // A pop is only ever issued with occupancy >= 1, so this cannot underflow.
  assign wr_idx   = occ_reg - OCC_W'(pop);
  assign occ_next = occ_reg + OCC_W'(push) - OCC_W'(pop);

  genvar gi;
  generate
    for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] shift_src;
      if (gi < SKID_DEPTH - 1) begin : g_mid
        assign shift_src = entry_reg[gi+1];
      end else begin : g_last
        assign shift_src = entry_reg[gi];
      end
      assign entry_next[gi] = (push && (wr_idx == OCC_W'(gi))) ? push_data :
                              pop                                ? shift_src :
                                                                   entry_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_reg <= '0;
      occ_reg   <= '0;
    end else begin
      entry_reg <= entry_next;
      occ_reg   <= occ_next;
    end
  end

  assign head      = entry_reg[0];
  assign occupancy = occ_reg;

endmodule

// File: rtl/pix_fifo_reader.sv
// Pulls pixels from a 1-cycle-latency FIFO into a valid/ready stream with frame markers.
// Define FRAME_MARKERS_EN to build the col/row counters behind m_sof/m_eol/m_eof.
module pix_fifo_reader
  import pix_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rden,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy
);

  logic [OCC_W-1:0] occupancy;
  logic             inflight_reg;
  logic             pop;
  logic [CNT_W-1:0] credit_used;
  state_t           state_reg;

  assign m_valid = (occupancy != '0);
  assign pop     = m_valid && m_ready;

  // A pop this cycle frees its slot before the requested word arrives, which is
  // what lets a steady stream run at one pixel per cycle.
  assign credit_used = CNT_W'(occupancy) + CNT_W'(inflight_reg) - CNT_W'(pop);
  assign fifo_rden   = rst_n && en && !fifo_empty && (credit_used < CNT_W'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) inflight_reg <= 1'b0;
    else        inflight_reg <= fifo_rden;
  end

  pix_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head      (m_data),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (en) state_reg <= ST_RUN;
        ST_RUN: begin
          if (!en) state_reg <= ((occupancy != '0) || inflight_reg) ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (en)                                       state_reg <= ST_RUN;
          else if ((occupancy == '0) && !inflight_reg)  state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_reg != ST_IDLE);

`ifdef FRAME_MARKERS_EN
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             col_last;
  logic             row_last;

  assign col_last = (col_reg == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_reg == ROW_W'(IMG_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (pop) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_reg <= col_reg + COL_W'(1);
      end
    end
  end

  assign m_sof = m_valid && (col_reg == '0) && (row_reg == '0);
  assign m_eol = m_valid && col_last;
  assign m_eof = m_eol && row_last;
`else
  assign m_sof = 1'b0;
  assign m_eol = 1'b0;
  assign m_eof = 1'b0;
`endif

endmodule
